// File: rtl/mesh_2x2_pkg.sv
// Shared definitions for the 2x2 mesh: widths, flit field positions,
// node coordinates, route directions and input-port arbitration order.
package mesh_2x2_pkg;

  localparam int FLIT_W    = 18;
  localparam int DATA_W    = 9;
  localparam int CFG_W     = 11;
  localparam int NUM_NODES = 4;
  localparam int NUM_PORTS = 4;

  // Flit layout: valid | dest | src | zero | data
  localparam int VALID_BIT = 17;
  localparam int DEST_MSB  = 16;
  localparam int DEST_LSB  = 15;
  localparam int SRC_MSB   = 14;
  localparam int SRC_LSB   = 13;
  localparam int DATA_MSB  = 8;
  localparam int DATA_LSB  = 0;

  // Processor request layout: dest | data
  localparam int CFG_DEST_MSB = 10;
  localparam int CFG_DEST_LSB = 9;

  // A node id packs its coordinates as {y, x}
  localparam int COORD_X_BIT = 0;
  localparam int COORD_Y_BIT = 1;

  // Input buffers; a lower value wins arbitration for a shared output
  typedef enum logic [1:0] {
    PORT_XIN   = 2'd0,
    PORT_YIN   = 2'd1,
    PORT_EXT   = 2'd2,
    PORT_LOCAL = 2'd3
  } port_e;

  typedef enum logic [1:0] {
    ROUTE_X     = 2'd0,
    ROUTE_Y     = 2'd1,
    ROUTE_EJECT = 2'd2
  } route_e;

  // Dimension-ordered routing: fix x first, then y, then leave the mesh
  function automatic route_e routeOf(input logic [1:0] dest, input logic [1:0] node);
    route_e r;
    if (dest[COORD_X_BIT] != node[COORD_X_BIT]) r = ROUTE_X;
    else if (dest[COORD_Y_BIT] != node[COORD_Y_BIT]) r = ROUTE_Y;
    else r = ROUTE_EJECT;
    return r;
  endfunction

  function automatic logic [FLIT_W-1:0] makeFlit(input logic [1:0] dest,
                                                 input logic [1:0] src,
                                                 input logic [DATA_W-1:0] data);
    logic [FLIT_W-1:0] f;
    f = '0;
    f[VALID_BIT] = 1'b1;
    f[DEST_MSB:DEST_LSB] = dest;
    f[SRC_MSB:SRC_LSB] = src;
    f[DATA_MSB:DATA_LSB] = data;
    return f;
  endfunction

  // Grant the lowest-numbered requesting port, i.e. the highest priority one
  function automatic logic [NUM_PORTS-1:0] pickFirst(input logic [NUM_PORTS-1:0] req);
    logic [NUM_PORTS-1:0] g;
    g = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (req[i] && (g == '0)) g[i] = 1'b1;
    end
    return g;
  endfunction

endpackage

// File: rtl/mesh_2x2_noc_router.sv
// One mesh router: four single-flit input buffers, XY route compute and a
// fixed-priority arbiter per output (X-link, Y-link, eject).
module noc_router
  import mesh_2x2_pkg::*;
#(
  parameter int NODE_ID = 0
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              block_i,
  input  logic              cfgReady_i,
  input  logic [CFG_W-1:0]  cfg_i,
  input  logic [FLIT_W-1:0] extIn_i,
  input  logic [FLIT_W-1:0] xinFlit_i,
  input  logic [FLIT_W-1:0] yinFlit_i,
  input  logic              xDownReady_i,
  input  logic              yDownReady_i,
  output logic [FLIT_W-1:0] xOut_o,
  output logic [FLIT_W-1:0] yOut_o,
  output logic              xinReady_o,
  output logic              yinReady_o,
  output logic              localEmpty_o,
  output logic [DATA_W-1:0] recvData_o,
  output logic [FLIT_W-1:0] ejectFlit_o
);

  localparam logic [1:0] NodeBits = 2'(NODE_ID);

  logic [FLIT_W-1:0]    bufQ [NUM_PORTS];
  logic [FLIT_W-1:0]    bufD [NUM_PORTS];
  logic [DATA_W-1:0]    recvQ, recvD;
  logic [FLIT_W-1:0]    ejQ, ejD;
  logic [FLIT_W-1:0]    ejFlit;
  logic [NUM_PORTS-1:0] validW, reqX, reqY, reqE;
  logic [NUM_PORTS-1:0] xGrant, yGrant, ejGrant, anyGrant;

  // Classify every occupied buffer by the output its flit needs next
  always_comb begin
    validW = '0;
    reqX = '0;
    reqY = '0;
    reqE = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      validW[p] = bufQ[p][VALID_BIT];
      if (bufQ[p][VALID_BIT]) begin
        case (routeOf(bufQ[p][DEST_MSB:DEST_LSB], NodeBits))
          ROUTE_X: reqX[p] = 1'b1;
          ROUTE_Y: reqY[p] = 1'b1;
          default: reqE[p] = 1'b1;
        endcase
      end
    end
  end

  // Eject never stalls; the links only move when the neighbour can take the flit.
  // The three grants are kept apart so buffer-free handshakes never loop through
  // the neighbouring routers.
  assign ejGrant  = block_i ? '0 : pickFirst(reqE);
  assign yGrant   = (block_i || !yDownReady_i) ? '0 : pickFirst(reqY);
  assign xGrant   = (block_i || !xDownReady_i) ? '0 : pickFirst(reqX);
  assign anyGrant = xGrant | yGrant | ejGrant;

  // A yin flit can only eject; an xin flit either ejects or turns onto Y
  assign yinReady_o   = !validW[PORT_YIN] || ejGrant[PORT_YIN];
  assign xinReady_o   = !validW[PORT_XIN] || ejGrant[PORT_XIN] || yGrant[PORT_XIN];
  assign localEmpty_o = !validW[PORT_LOCAL];

  // Steer the granted flits onto the links and the eject path
  always_comb begin
    xOut_o = '0;
    yOut_o = '0;
    ejFlit = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (xGrant[p])  xOut_o = bufQ[p];
      if (yGrant[p])  yOut_o = bufQ[p];
      if (ejGrant[p]) ejFlit = bufQ[p];
    end
  end

  // Next buffer contents: departures empty a slot, arrivals and injections fill it
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      bufD[p] = anyGrant[p] ? '0 : bufQ[p];
    end
    if (xinFlit_i[VALID_BIT]) bufD[PORT_XIN] = xinFlit_i;
    if (yinFlit_i[VALID_BIT]) bufD[PORT_YIN] = yinFlit_i;
    if (!block_i && !validW[PORT_EXT] && extIn_i[VALID_BIT]) bufD[PORT_EXT] = extIn_i;
    if (cfgReady_i && (cfg_i != '0)) begin
      bufD[PORT_LOCAL] = makeFlit(cfg_i[CFG_DEST_MSB:CFG_DEST_LSB], NodeBits,
                                  cfg_i[DATA_MSB:DATA_LSB]);
    end
    recvD = ejFlit[VALID_BIT] ? ejFlit[DATA_MSB:DATA_LSB] : recvQ;
    ejD   = ejFlit;
  end

  // State register with synchronous reset that drops every in-flight flit
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int p = 0; p < NUM_PORTS; p++) bufQ[p] <= '0;
      recvQ <= '0;
      ejQ   <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) bufQ[p] <= bufD[p];
      recvQ <= recvD;
      ejQ   <= ejD;
    end
  end

  assign recvData_o  = recvQ;
  assign ejectFlit_o = block_i ? '0 : ejQ;

endmodule

// File: rtl/mesh_2x2.sv
// 2x2 mesh top: four routers joined by X links (0-1, 2-3) and Y links (0-2, 1-3).
module mesh_2x2
  import mesh_2x2_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [FLIT_W-1:0] r0_input,
  input  logic [FLIT_W-1:0] r1_input,
  input  logic [FLIT_W-1:0] r2_input,
  input  logic [FLIT_W-1:0] r3_input,
  input  logic [CFG_W-1:0]  p0_configure,
  input  logic [CFG_W-1:0]  p1_configure,
  input  logic [CFG_W-1:0]  p2_configure,
  input  logic [CFG_W-1:0]  p3_configure,
  input  logic              block_all_paths,
  output logic [3:0]        processor_ready_signals,
  output logic [DATA_W-1:0] p0_recieve_data,
  output logic [DATA_W-1:0] p1_recieve_data,
  output logic [DATA_W-1:0] p2_recieve_data,
  output logic [DATA_W-1:0] p3_recieve_data,
  output logic [FLIT_W-1:0] r0_output,
  output logic [FLIT_W-1:0] r1_output,
  output logic [FLIT_W-1:0] r2_output,
  output logic [FLIT_W-1:0] r3_output
);

  logic [FLIT_W-1:0]    extIn [NUM_NODES];
  logic [CFG_W-1:0]     cfg   [NUM_NODES];
  logic [DATA_W-1:0]    recv  [NUM_NODES];
  logic [FLIT_W-1:0]    ejOut [NUM_NODES];
  logic [FLIT_W-1:0]    xLink [NUM_NODES];
  logic [FLIT_W-1:0]    yLink [NUM_NODES];
  logic [NUM_NODES-1:0] xinRdy, yinRdy, localEmpty;

  assign extIn[0] = r0_input;
  assign extIn[1] = r1_input;
  assign extIn[2] = r2_input;
  assign extIn[3] = r3_input;
  assign cfg[0]   = p0_configure;
  assign cfg[1]   = p1_configure;
  assign cfg[2]   = p2_configure;
  assign cfg[3]   = p3_configure;

  assign p0_recieve_data = recv[0];
  assign p1_recieve_data = recv[1];
  assign p2_recieve_data = recv[2];
  assign p3_recieve_data = recv[3];
  assign r0_output = ejOut[0];
  assign r1_output = ejOut[1];
  assign r2_output = ejOut[2];
  assign r3_output = ejOut[3];

  // A processor may inject only into an empty local buffer of a running mesh
  assign processor_ready_signals = localEmpty & {NUM_NODES{~block_all_paths & ~reset}};

  // X neighbour of node i is i^1, Y neighbour is i^2
  for (genvar i = 0; i < NUM_NODES; i++) begin : gRouter
    noc_router #(.NODE_ID(i)) uRouter (
      .clock_i      (clock),
      .reset_i      (reset),
      .block_i      (block_all_paths),
      .cfgReady_i   (processor_ready_signals[i]),
      .cfg_i        (cfg[i]),
      .extIn_i      (extIn[i]),
      .xinFlit_i    (xLink[i ^ 1]),
      .yinFlit_i    (yLink[i ^ 2]),
      .xDownReady_i (xinRdy[i ^ 1]),
      .yDownReady_i (yinRdy[i ^ 2]),
      .xOut_o       (xLink[i]),
      .yOut_o       (yLink[i]),
      .xinReady_o   (xinRdy[i]),
      .yinReady_o   (yinRdy[i]),
      .localEmpty_o (localEmpty[i]),
      .recvData_o   (recv[i]),
      .ejectFlit_o  (ejOut[i])
    );
  end

endmodule

// File: tb/tb_mesh_2x2.sv
// Self-checking bench for mesh_2x2: directed scenarios followed by random
// single-flit traffic checked against hop-count latency arithmetic.
module tb_mesh_2x2;

  logic        clock = 1'b0;
  logic        reset;
  logic [17:0] r0_input, r1_input, r2_input, r3_input;
  logic [10:0] p0_configure, p1_configure, p2_configure, p3_configure;
  logic        block_all_paths;
  logic [3:0]  processor_ready_signals;
  logic [8:0]  p0_recieve_data, p1_recieve_data, p2_recieve_data, p3_recieve_data;
  logic [17:0] r0_output, r1_output, r2_output, r3_output;

  int compared = 0;
  int mismatched = 0;
  logic [8:0] recvModel [4];

  mesh_2x2 dut (
    .clock                   (clock),
    .reset                   (reset),
    .r0_input                (r0_input),
    .r1_input                (r1_input),
    .r2_input                (r2_input),
    .r3_input                (r3_input),
    .p0_configure            (p0_configure),
    .p1_configure            (p1_configure),
    .p2_configure            (p2_configure),
    .p3_configure            (p3_configure),
    .block_all_paths         (block_all_paths),
    .processor_ready_signals (processor_ready_signals),
    .p0_recieve_data         (p0_recieve_data),
    .p1_recieve_data         (p1_recieve_data),
    .p2_recieve_data         (p2_recieve_data),
    .p3_recieve_data         (p3_recieve_data),
    .r0_output               (r0_output),
    .r1_output               (r1_output),
    .r2_output               (r2_output),
    .r3_output               (r3_output)
  );

  always #5 clock = ~clock;

  function automatic logic [17:0] mkFlit(input logic [1:0] d, input logic [1:0] s,
                                         input logic [8:0] data);
    return {1'b1, d, s, 4'b0000, data};
  endfunction

  function automatic logic [71:0] placeOut(input int node, input logic [17:0] f);
    logic [71:0] v;
    v = '0;
    v[node*18 +: 18] = f;
    return v;
  endfunction

  function automatic logic [35:0] recvVec();
    return {p3_recieve_data, p2_recieve_data, p1_recieve_data, p0_recieve_data};
  endfunction

  function automatic logic [71:0] outVec();
    return {r3_output, r2_output, r1_output, r0_output};
  endfunction

  function automatic logic [35:0] modelVec();
    return {recvModel[3], recvModel[2], recvModel[1], recvModel[0]};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int node, input logic [10:0] cfg, input logic [17:0] ext);
    case (node)
      0: begin p0_configure = cfg; r0_input = ext; end
      1: begin p1_configure = cfg; r1_input = ext; end
      2: begin p2_configure = cfg; r2_input = ext; end
      default: begin p3_configure = cfg; r3_input = ext; end
    endcase
  endtask

  task automatic clearStimulus();
    for (int n = 0; n < 4; n++) applyStimulus(n, 11'b0, 18'b0);
  endtask

  initial begin
    reset = 1'b1;
    block_all_paths = 1'b0;
    clearStimulus();
    #1;
    checkOutput("ready_in_reset", 128'(processor_ready_signals), 128'(4'b0000));

    // Reset for one cycle, then idle
    tick();
    reset = 1'b0;
    #1;
    checkOutput("reset_ready", 128'(processor_ready_signals), 128'(4'b1111));
    checkOutput("reset_recv", 128'(recvVec()), 128'(36'b0));
    checkOutput("reset_out", 128'(outVec()), 128'(72'b0));

    // Contention: p2 and p3 both send to node 1 on the same edge
    applyStimulus(2, 11'b01_000000011, 18'b0);
    applyStimulus(3, 11'b01_000000001, 18'b0);
    tick();
    clearStimulus();
    checkOutput("cont_ready_k", 128'(processor_ready_signals), 128'(4'b0011));
    tick();
    checkOutput("cont_ready_k1", 128'(processor_ready_signals), 128'(4'b1111));
    checkOutput("cont_recv_k1", 128'(recvVec()), 128'(36'b0));
    tick();
    checkOutput("cont_p1_k2", 128'(p1_recieve_data), 128'(9'd1));
    checkOutput("cont_out_k2", 128'(outVec()), 128'(placeOut(1, mkFlit(2'd1, 2'd3, 9'd1))));
    tick();
    checkOutput("cont_p1_k3", 128'(p1_recieve_data), 128'(9'd3));
    checkOutput("cont_out_k3", 128'(outVec()), 128'(placeOut(1, mkFlit(2'd1, 2'd2, 9'd3))));
    tick();
    checkOutput("cont_out_k4", 128'(outVec()), 128'(72'b0));
    checkOutput("cont_recv_k4", 128'(recvVec()), 128'({9'd0, 9'd0, 9'd3, 9'd0}));

    // Two-hop diagonal 0 -> 3: delivered h+1 = 3 edges after injection
    applyStimulus(0, 11'b11_000001010, 18'b0);
    tick();
    clearStimulus();
    tick();
    checkOutput("diag_recv_k1", 128'(recvVec()), 128'({9'd0, 9'd0, 9'd3, 9'd0}));
    tick();
    checkOutput("diag_recv_k2", 128'(recvVec()), 128'({9'd0, 9'd0, 9'd3, 9'd0}));
    tick();
    checkOutput("diag_recv_k3", 128'(recvVec()), 128'({9'd10, 9'd0, 9'd3, 9'd0}));
    checkOutput("diag_out_k3", 128'(outVec()), 128'(placeOut(3, mkFlit(2'd3, 2'd0, 9'd10))));
    tick();
    checkOutput("diag_out_k4", 128'(outVec()), 128'(72'b0));

    // External flit addressed to its own router
    applyStimulus(0, 11'b0, mkFlit(2'd0, 2'd0, 9'h1FF));
    tick();
    clearStimulus();
    tick();
    checkOutput("local_recv", 128'(recvVec()), 128'({9'd10, 9'd0, 9'd3, 9'h1FF}));
    checkOutput("local_out", 128'(outVec()), 128'(placeOut(0, mkFlit(2'd0, 2'd0, 9'h1FF))));
    tick();
    checkOutput("local_recv_hold", 128'(recvVec()), 128'({9'd10, 9'd0, 9'd3, 9'h1FF}));
    checkOutput("local_out_clear", 128'(outVec()), 128'(72'b0));

    // Freeze a 2 -> 1 flit after its first hop, then release it
    applyStimulus(2, 11'b01_000000101, 18'b0);
    tick();
    clearStimulus();
    tick();
    block_all_paths = 1'b1;
    #1;
    checkOutput("block_ready", 128'(processor_ready_signals), 128'(4'b0000));
    applyStimulus(1, 11'b0, mkFlit(2'd1, 2'd1, 9'h077));
    for (int b = 0; b < 3; b++) begin
      tick();
      clearStimulus();
      checkOutput("block_recv", 128'(recvVec()), 128'({9'd10, 9'd0, 9'd3, 9'h1FF}));
      checkOutput("block_out", 128'(outVec()), 128'(72'b0));
      checkOutput("block_ready_held", 128'(processor_ready_signals), 128'(4'b0000));
    end
    block_all_paths = 1'b0;
    #1;
    checkOutput("release_ready", 128'(processor_ready_signals), 128'(4'b1111));
    tick();
    checkOutput("release_recv_1", 128'(recvVec()), 128'({9'd10, 9'd0, 9'd3, 9'h1FF}));
    tick();
    checkOutput("release_recv_2", 128'(recvVec()), 128'({9'd10, 9'd0, 9'd5, 9'h1FF}));
    checkOutput("release_out_2", 128'(outVec()), 128'(placeOut(1, mkFlit(2'd1, 2'd2, 9'd5))));
    tick();
    tick();
    checkOutput("release_no_ext", 128'(recvVec()), 128'({9'd10, 9'd0, 9'd5, 9'h1FF}));
    checkOutput("release_out_idle", 128'(outVec()), 128'(72'b0));

    // Reset while a flit sits one hop from its destination
    applyStimulus(3, 11'b01_010101010, 18'b0);
    tick();
    clearStimulus();
    reset = 1'b1;
    #1;
    checkOutput("midreset_ready", 128'(processor_ready_signals), 128'(4'b0000));
    tick();
    checkOutput("midreset_recv", 128'(recvVec()), 128'(36'b0));
    checkOutput("midreset_out", 128'(outVec()), 128'(72'b0));
    reset = 1'b0;
    for (int w = 0; w < 3; w++) begin
      tick();
      checkOutput("midreset_no_delivery", 128'(recvVec()), 128'(36'b0));
      checkOutput("midreset_out_idle", 128'(outVec()), 128'(72'b0));
    end
    checkOutput("midreset_ready_after", 128'(processor_ready_signals), 128'(4'b1111));

    // Random single flits: ejected hops+1 edges after injection
    for (int n = 0; n < 4; n++) recvModel[n] = 9'd0;
    for (int it = 0; it < 24; it++) begin
      int          s;
      int          d;
      int          hops;
      logic [8:0]  data;
      logic        useExt;
      logic [17:0] f;
      s = int'($urandom_range(0, 3));
      d = int'($urandom_range(0, 3));
      data = 9'($urandom_range(1, 511));
      useExt = 1'($urandom_range(0, 1));
      hops = int'(s[0] ^ d[0]) + int'(s[1] ^ d[1]);
      f = mkFlit(2'(d), 2'(s), data);
      if (useExt) applyStimulus(s, 11'b0, f);
      else applyStimulus(s, {2'(d), data}, 18'b0);
      tick();
      clearStimulus();
      for (int e = 1; e <= hops + 1; e++) begin
        tick();
        if (e == hops + 1) recvModel[d] = data;
        checkOutput("rand_recv", 128'(recvVec()), 128'(modelVec()));
        checkOutput("rand_out", 128'(outVec()),
                    128'((e == hops + 1) ? placeOut(d, f) : 72'b0));
      end
    end
    tick();
    checkOutput("rand_ready_end", 128'(processor_ready_signals), 128'(4'b1111));
    checkOutput("rand_out_end", 128'(outVec()), 128'(72'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
